// File: rtl/conv_3x3_channel_acc.sv
// conv_3x3_channel_acc
// Accumulates per-input-channel partial results from the 3x3 convolution core
// across CHANNEL_NUM_IN channels in an image-sized accumulator RAM. On the last
// input channel it adds the per-output-channel bias, applies optional ReLU and
// emits the finished output-channel image in raster order.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   valid_in      pxl_in carries one partial result this cycle
//   pxl_in        signed partial sum for the current pixel / input channel
//   valid_bias_in load bias_in into the bias register
//   bias_in       bias for the current output channel
//   pxl_out       finished output pixel (holds while valid_out = 0)
//   valid_out     one-cycle strobe per finished pixel, 2 clocks after valid_in
//   ch_done       strobes with the last pixel of each output channel
//   frame_done    strobes with the last pixel of output channel CHANNEL_NUM_OUT-1
module conv_3x3_channel_acc #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_WIDTH     = 64,
  parameter int IMAGE_HEIGHT    = 64,
  parameter int CHANNEL_NUM_IN  = 64,
  parameter int CHANNEL_NUM_OUT = 256,
  parameter int RELU_EN         = 1,
  parameter int IMAGE_SIZE      = IMAGE_WIDTH * IMAGE_HEIGHT,
  parameter int ADDR_WIDTH      = $clog2(IMAGE_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  valid_bias_in,
  input  logic [DATA_WIDTH-1:0] bias_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  ch_done,
  output logic                  frame_done
);

  localparam int ICH_W = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int OCH_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;

  localparam logic [ADDR_WIDTH-1:0] PIX_LAST = ADDR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] PIX_ONE  = ADDR_WIDTH'(1);
  localparam logic [ICH_W-1:0]      ICH_LAST = ICH_W'(CHANNEL_NUM_IN - 1);
  localparam logic [ICH_W-1:0]      ICH_ONE  = ICH_W'(1);
  localparam logic [OCH_W-1:0]      OCH_LAST = OCH_W'(CHANNEL_NUM_OUT - 1);
  localparam logic [OCH_W-1:0]      OCH_ONE  = OCH_W'(1);

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Add at DATA_WIDTH+1 bits and clamp to the signed DATA_WIDTH range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      if (s[DATA_WIDTH]) begin
        sat_add = SAT_MIN;
      end else begin
        sat_add = SAT_MAX;
      end
    end else begin
      sat_add = s[DATA_WIDTH-1:0];
    end
  endfunction

  logic [ADDR_WIDTH-1:0] pix_cnt_r;
  logic [ICH_W-1:0]      ich_cnt_r;
  logic [OCH_W-1:0]      och_cnt_r;

  logic                         s1_vld_r;
  logic signed [DATA_WIDTH-1:0] s1_pxl_r;
  logic [ADDR_WIDTH-1:0]        s1_addr_r;
  logic                         s1_first_r;
  logic                         s1_last_r;
  logic                         s1_pix_last_r;
  logic                         s1_och_last_r;

  logic signed [DATA_WIDTH-1:0] acc_ram [IMAGE_SIZE];
  logic signed [DATA_WIDTH-1:0] ram_q_r;
  logic signed [DATA_WIDTH-1:0] bias_r;

  logic signed [DATA_WIDTH-1:0] sum_s;
  logic signed [DATA_WIDTH-1:0] biased_s;
  logic signed [DATA_WIDTH-1:0] result_s;
  logic                         wr_en_s;

  // Position counters: pixel within image, input channel, output channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt_r <= '0;
      ich_cnt_r <= '0;
      och_cnt_r <= '0;
    end else if (valid_in) begin
      if (pix_cnt_r == PIX_LAST) begin
        pix_cnt_r <= '0;
        if (ich_cnt_r == ICH_LAST) begin
          ich_cnt_r <= '0;
          if (och_cnt_r == OCH_LAST) begin
            och_cnt_r <= '0;
          end else begin
            och_cnt_r <= och_cnt_r + OCH_ONE;
          end
        end else begin
          ich_cnt_r <= ich_cnt_r + ICH_ONE;
        end
      end else begin
        pix_cnt_r <= pix_cnt_r + PIX_ONE;
      end
    end
  end

  // Stage 1: capture the partial and its position tags alongside the RAM read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_r      <= 1'b0;
      s1_pxl_r      <= '0;
      s1_addr_r     <= '0;
      s1_first_r    <= 1'b0;
      s1_last_r     <= 1'b0;
      s1_pix_last_r <= 1'b0;
      s1_och_last_r <= 1'b0;
    end else begin
      s1_vld_r <= valid_in;
      if (valid_in) begin
        s1_pxl_r      <= pxl_in;
        s1_addr_r     <= pix_cnt_r;
        s1_first_r    <= (ich_cnt_r == '0);
        s1_last_r     <= (ich_cnt_r == ICH_LAST);
        s1_pix_last_r <= (pix_cnt_r == PIX_LAST);
        s1_och_last_r <= (och_cnt_r == OCH_LAST);
      end
    end
  end

  // Accumulator RAM: synchronous read with the input, write-back of
  // intermediate sums. Contents need no reset because channel 0 overwrites.
  // Read and write addresses in one cycle always differ (consecutive pixels).
  always_ff @(posedge clk) begin
    if (valid_in) begin
      ram_q_r <= acc_ram[pix_cnt_r];
    end
    if (wr_en_s) begin
      acc_ram[s1_addr_r] <= sum_s;
    end
  end

  // Bias register; a load coinciding with an output uses the old value there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bias_r <= '0;
    end else if (valid_bias_in) begin
      bias_r <= bias_in;
    end
  end

  // Stage 2: accumulate (first channel ignores stale RAM), bias and ReLU.
  always_comb begin
    sum_s    = s1_pxl_r;
    biased_s = '0;
    result_s = '0;
    if (s1_first_r) begin
      sum_s = s1_pxl_r;
    end else begin
      sum_s = sat_add(ram_q_r, s1_pxl_r);
    end
    wr_en_s  = s1_vld_r & ~s1_last_r;
    biased_s = sat_add(sum_s, bias_r);
    if ((RELU_EN != 32'sd0) && biased_s[DATA_WIDTH-1]) begin
      result_s = '0;
    end else begin
      result_s = biased_s;
    end
  end

  // Output register: strobes only for last-channel pixels, value held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      ch_done    <= 1'b0;
      frame_done <= 1'b0;
    end else if (s1_vld_r && s1_last_r) begin
      pxl_out    <= result_s;
      valid_out  <= 1'b1;
      ch_done    <= s1_pix_last_r;
      frame_done <= s1_pix_last_r & s1_och_last_r;
    end else begin
      valid_out  <= 1'b0;
      ch_done    <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_3x3_channel_acc.sv
// tb_conv_3x3_channel_acc
// Three instances on a 2x2 image, 3 input channels, 2 output channels:
//   u0: 32-bit, no ReLU   u1: 32-bit, ReLU   u2: 8-bit, no ReLU
// A directed vector table and randomized channels are streamed in; a reference
// model computes expected pixels (with arrival time, ch_done, frame_done) into
// per-instance queues, and a negedge monitor checks every DUT output cycle.
module tb_conv_3x3_channel_acc;

  localparam int P = 10;

  logic clk;
  logic rst_n;
  logic        vin [3];
  logic [31:0] pin [3];
  logic        vb  [3];
  logic [31:0] bin [3];

  logic [31:0] po0, po1;
  logic [7:0]  po2;
  logic        vo0, vo1, vo2;
  logic        cd0, cd1, cd2;
  logic        fd0, fd1, fd2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    time    t;
    longint v;
    bit     cd;
    bit     fd;
  } exp_t;

  exp_t exp_q [3][$];
  int   och_m [3];

  typedef struct {
    int inst;
    int bias;
    int gap;
    int sw_px;
    int bias2;
    int p  [0:2][0:3];
    int ev [0:3];
  } vec_t;

  vec_t tbl [6];

  conv_3x3_channel_acc #(.DATA_WIDTH(32), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
    .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2), .RELU_EN(0)) u0 (
    .clk(clk), .reset(rst_n), .valid_in(vin[0]), .pxl_in(pin[0]),
    .valid_bias_in(vb[0]), .bias_in(bin[0]), .pxl_out(po0),
    .valid_out(vo0), .ch_done(cd0), .frame_done(fd0));

  conv_3x3_channel_acc #(.DATA_WIDTH(32), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
    .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2), .RELU_EN(1)) u1 (
    .clk(clk), .reset(rst_n), .valid_in(vin[1]), .pxl_in(pin[1]),
    .valid_bias_in(vb[1]), .bias_in(bin[1]), .pxl_out(po1),
    .valid_out(vo1), .ch_done(cd1), .frame_done(fd1));

  conv_3x3_channel_acc #(.DATA_WIDTH(8), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
    .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(2), .RELU_EN(0)) u2 (
    .clk(clk), .reset(rst_n), .valid_in(vin[2]), .pxl_in(pin[2][7:0]),
    .valid_bias_in(vb[2]), .bias_in(bin[2][7:0]), .pxl_out(po2),
    .valid_out(vo2), .ch_done(cd2), .frame_done(fd2));

  initial clk = 1'b0;
  always #(P/2) clk = ~clk;

  function automatic longint sat_m(input longint v, input int dw);
    longint hi, lo;
    hi = (longint'(1) <<< (dw - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  task automatic chk(input string nm, input longint got, input longint expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
    end
  endtask

  task automatic check_out(input int inst, input logic vo, input longint pv,
                           input logic cd, input logic fd);
    exp_t e;
    n_checks++;
    if (vo) begin
      if (exp_q[inst].size() == 0) begin
        n_fail++;
        $display("FAIL out%0d: unexpected valid_out with value %0d at t=%0t, expected no output",
                 inst, pv, $time);
      end else begin
        e = exp_q[inst].pop_front();
        if (e.t != $time || e.v != pv || e.cd != cd || e.fd != fd) begin
          n_fail++;
          $display("FAIL out%0d: got val=%0d ch_done=%0b frame_done=%0b t=%0t, expected val=%0d ch_done=%0b frame_done=%0b t=%0t",
                   inst, pv, cd, fd, $time, e.v, e.cd, e.fd, e.t);
        end
      end
    end else if (cd || fd) begin
      n_fail++;
      $display("FAIL strobe%0d: ch_done=%0b frame_done=%0b without valid_out, expected 0",
               inst, cd, fd);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    check_out(0, vo0, longint'($signed(po0)), cd0, fd0);
    check_out(1, vo1, longint'($signed(po1)), cd1, fd1);
    check_out(2, vo2, longint'($signed(po2)), cd2, fd2);
  end

  // Stream one output channel (3 input channels x 4 pixels) into one instance.
  task automatic run_och(input int inst, input int bias, input int p [0:2][0:3],
                         input int gap_max, input int sw_px, input int bias2,
                         input bit use_tbl, input int tv [0:3]);
    longint acc, r, b;
    int dw;
    exp_t e;
    dw = (inst == 2) ? 8 : 32;
    @(negedge clk);
    vb[inst]  = 1'b1;
    bin[inst] = bias;
    for (int c = 0; c < 3; c++) begin
      for (int px = 0; px < 4; px++) begin
        if (gap_max > 0) begin
          repeat ($urandom_range(0, gap_max)) begin
            @(negedge clk);
            vin[inst] = 1'b0;
            vb[inst]  = 1'b0;
          end
        end
        @(negedge clk);
        vb[inst]  = 1'b0;
        vin[inst] = 1'b1;
        pin[inst] = p[c][px];
        if (c == 2 && px == sw_px) begin
          vb[inst]  = 1'b1;
          bin[inst] = bias2;
        end
        if (c == 2) begin
          acc = sat_m(longint'(p[0][px]), dw);
          for (int k = 1; k < 3; k++) acc = sat_m(acc + longint'(p[k][px]), dw);
          b = (sw_px >= 0 && px >= sw_px) ? longint'(bias2) : longint'(bias);
          r = sat_m(acc + b, dw);
          if (inst == 1 && r < 0) r = 0;
          if (use_tbl) r = tv[px];
          e.t  = $time + 2 * P;
          e.v  = r;
          e.cd = (px == 3);
          e.fd = (px == 3) && (och_m[inst] == 1);
          exp_q[inst].push_back(e);
        end
      end
    end
    @(negedge clk);
    vin[inst] = 1'b0;
    vb[inst]  = 1'b0;
    och_m[inst] = (och_m[inst] + 1) % 2;
  endtask

  task automatic run_tbl(input int i);
    run_och(tbl[i].inst, tbl[i].bias, tbl[i].p, tbl[i].gap, tbl[i].sw_px,
            tbl[i].bias2, 1'b1, tbl[i].ev);
  endtask

  initial begin
    int rp [0:2][0:3];
    int none [0:3];
    int b;

    tbl[0].inst = 0; tbl[0].bias = 10; tbl[0].gap = 0; tbl[0].sw_px = -1; tbl[0].bias2 = 0;
    tbl[0].p  = '{'{1, 2, 3, 4}, '{10, 20, 30, 40}, '{100, 200, 300, 400}};
    tbl[0].ev = '{121, 232, 343, 454};
    tbl[1].inst = 0; tbl[1].bias = -5; tbl[1].gap = 0; tbl[1].sw_px = -1; tbl[1].bias2 = 0;
    tbl[1].p  = '{'{1, 1, 1, 1}, '{1, 1, 1, 1}, '{1, 1, 1, 1}};
    tbl[1].ev = '{-2, -2, -2, -2};
    tbl[2].inst = 1; tbl[2].bias = 0; tbl[2].gap = 0; tbl[2].sw_px = -1; tbl[2].bias2 = 0;
    tbl[2].p  = '{'{-7, 1, 10, 100}, '{-7, 2, 0, -50}, '{-7, 3, 0, 1}};
    tbl[2].ev = '{0, 6, 10, 51};
    tbl[3].inst = 2; tbl[3].bias = 0; tbl[3].gap = 0; tbl[3].sw_px = -1; tbl[3].bias2 = 0;
    tbl[3].p  = '{'{100, -100, 50, -1}, '{100, -100, 50, -1}, '{100, -100, -20, -1}};
    tbl[3].ev = '{127, -128, 80, -3};
    tbl[4] = tbl[0];
    tbl[4].gap = 5;
    tbl[5].inst = 0; tbl[5].bias = 7; tbl[5].gap = 0; tbl[5].sw_px = 2; tbl[5].bias2 = 1000;
    tbl[5].p  = '{'{1, 1, 1, 1}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    tbl[5].ev = '{8, 8, 1001, 1001};
    none = '{0, 0, 0, 0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; pin[i] = 32'd0; vb[i] = 1'b0; bin[i] = 32'd0; och_m[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst pxl_out0", longint'(po0), 0);   chk("rst valid_out0", longint'(vo0), 0);
    chk("rst ch_done0", longint'(cd0), 0);   chk("rst frame_done0", longint'(fd0), 0);
    chk("rst pxl_out1", longint'(po1), 0);   chk("rst valid_out1", longint'(vo1), 0);
    chk("rst ch_done1", longint'(cd1), 0);   chk("rst frame_done1", longint'(fd1), 0);
    chk("rst pxl_out2", longint'(po2), 0);   chk("rst valid_out2", longint'(vo2), 0);
    chk("rst ch_done2", longint'(cd2), 0);   chk("rst frame_done2", longint'(fd2), 0);
    rst_n = 1'b1;

    // Directed table: frame on u0, ReLU on u1, saturation on u2, gaps, bias switch.
    for (int i = 0; i < 2; i++) run_tbl(i);
    run_tbl(2);
    run_tbl(3);
    run_tbl(4);
    run_tbl(5);
    repeat (4) @(negedge clk);

    // Randomized channels with gaps; two output channels per instance = one frame.
    for (int inst = 0; inst < 3; inst++) begin
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < 3; c++) begin
          for (int px = 0; px < 4; px++) begin
            if (inst == 2) rp[c][px] = int'($urandom_range(0, 255)) - 128;
            else           rp[c][px] = int'($urandom_range(0, 4000)) - 2000;
          end
        end
        if (inst == 2) b = int'($urandom_range(0, 255)) - 128;
        else           b = int'($urandom_range(0, 2000)) - 1000;
        run_och(inst, b, rp, 3, -1, 0, 1'b0, none);
      end
    end
    repeat (4) @(negedge clk);

    // Reset in the middle of input channel 1, then replay a fresh frame.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vin[0] = 1'b1;
      pin[0] = 32'd555 + 32'(i);
    end
    @(negedge clk);
    vin[0] = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("midrst pxl_out0", longint'(po0), 0);
    chk("midrst valid_out0", longint'(vo0), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) och_m[i] = 0;
    run_tbl(0);
    run_tbl(1);
    repeat (4) @(negedge clk);

    chk("pending outputs u0", longint'(exp_q[0].size()), 0);
    chk("pending outputs u1", longint'(exp_q[1].size()), 0);
    chk("pending outputs u2", longint'(exp_q[2].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_3x3_channel_acc.md
Name: conv_3x3_channel_acc

Overview:
Downstream stage of the 3x3 convolution top. Consumes its per-input-channel partial results, which arrive channel-major: a full image for input channel 0, then channel 1, and so on. Accumulates those partials across CHANNEL_NUM_IN channels in an image-sized accumulator RAM, adds a per-output-channel bias, and applies optional ReLU. Emits one finished output-channel image in raster order while the last input channel streams in.

Parameters:
DATA_WIDTH, 32, signed two's-complement fixed-point word width for all data.
IMAGE_WIDTH, 64, image width in pixels.
IMAGE_HEIGHT, 64, image height in pixels.
CHANNEL_NUM_IN, 64, input channels summed per output pixel.
CHANNEL_NUM_OUT, 256, output channels per frame.
RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass signed result.
IMAGE_SIZE, IMAGE_WIDTH*IMAGE_HEIGHT, accumulator depth (derived, must be >= 2).
ADDR_WIDTH, $clog2(IMAGE_SIZE), accumulator address width (derived).

Ports:
clk  input  1  single clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
valid_in  input  1  pxl_in carries one partial result this cycle.
pxl_in  input  DATA_WIDTH  partial sum from the 3x3 core for the current pixel and input channel.
valid_bias_in  input  1  load bias_in into the bias register.
bias_in  input  DATA_WIDTH  bias for the current output channel.
pxl_out  output  DATA_WIDTH  finished output pixel.
valid_out  output  1  pxl_out valid, one-cycle strobe per pixel.
ch_done  output  1  pulses with the last pixel of each output channel.
frame_done  output  1  pulses with the last pixel of output channel CHANNEL_NUM_OUT-1.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - pxl_out, valid_out, ch_done and frame_done to 0;
  - pixel counter, input-channel counter and output-channel counter to 0;
  - bias register and pipeline valids to 0.
- Accumulator RAM contents are not reset. Channel 0 overwrites every entry, so stale contents never reach the output.
- Counters advance only on valid_in=1. valid_in may be gapped arbitrarily with no minimum spacing; back-to-back cycles sustain 1 pixel/clk.
  - pix_cnt wraps IMAGE_SIZE-1 -> 0 and increments ich_cnt.
  - ich_cnt wraps CHANNEL_NUM_IN-1 -> 0 and increments och_cnt.
  - och_cnt wraps CHANNEL_NUM_OUT-1 -> 0.
- Stage 1, the cycle of valid_in: issue a synchronous RAM read at pix_cnt; register pxl_in, pix_cnt, first = (ich_cnt==0) and last = (ich_cnt==CHANNEL_NUM_IN-1).
- Stage 2, one cycle later, computes sum:
  - first=1: sum = pxl_in_d.
  - otherwise: sum = sat(ram_q + pxl_in_d).
  - When last=0, sum is written back to RAM at the registered address.
  - When CHANNEL_NUM_IN==1, first and last are both set: bias is added directly and there is no RAM read dependency.
- Output register, when last=1: result = sat(sum + bias_reg); if RELU_EN and result<0, result = 0. pxl_out <= result and valid_out <= 1. No RAM write is needed on the last channel.
- Latency from valid_in to valid_out is 2 clocks, fixed.
- valid_out is 0 in all cycles not driven by a last-channel input. pxl_out holds its last value while valid_out=0.
- ch_done = valid_out for pixel IMAGE_SIZE-1. frame_done = ch_done when och_cnt was CHANNEL_NUM_OUT-1. Both are registered, aligned with valid_out.
- Saturation: two's-complement add at DATA_WIDTH+1 bits, clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Read-after-write: consecutive accesses always target different addresses because IMAGE_SIZE >= 2, so no bypass path is required.
- Bias register:
  - Loads on any cycle with valid_bias_in=1.
  - The value sampled is the one present when each last-channel pixel reaches the output-register addition. A load during the last-channel pass affects only later pixels.
  - valid_bias_in concurrent with a pixel at that stage: the pixel uses the old bias.
- Reset mid-stream aborts all counters and the pipeline. The next valid_in is treated as pixel 0, input channel 0, output channel 0.

Test Plan:
- Params 2x2 image, CHANNEL_NUM_IN=3, CHANNEL_NUM_OUT=2, RELU_EN=0:
  - stimulus: bias=10; channels feed 1,2,3,4 / 10,20,30,40 / 100,200,300,400 back-to-back;
  - required: valid_out on exactly the 4 last-channel pixels, 2 clk after each, values 121,232,343,454, ch_done on 454.
- Continue with bias=-5 for output channel 1, all partials 1:
  - required: four outputs of -2 (3 partials of 1 plus bias -5);
  - frame_done pulses with the fourth output, then counters return to 0.
- RELU_EN=1 with a negative sum (-7,-7,-7, bias 0) -> pxl_out=0; positive sums pass unchanged.
- Saturation, DATA_WIDTH=8: partials 100,100,100 -> 127; partials -100,-100,-100 with RELU_EN=0 -> -128.
- Random valid_in gaps, 0-5 idle cycles -> outputs identical to the back-to-back case, and valid_out never asserted during non-last channels.
- Assert reset mid channel 1, then replay a full frame -> results match a fresh run, with no stale accumulator contribution.
